// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N requesters.
// Each winning word is latched, then written when the FIFO is not full.
module fifo_wr_arbiter #(
  parameter int W = 6,
  parameter int N = 4
) (
  input  logic           r_clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   ack,
  input  logic           fifo_full,
  output logic           fifo_we,
  output logic [W-1:0]   fifo_data,
  output logic           busy,
  output logic [7:0]     stall_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [W-1:0]  data_q, data_d;
  logic [7:0]    stall_q, stall_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest set request after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = IW'((int'(rr_ptr_q) + off) % N);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    data_d   = data_q;
    stall_d  = stall_q;
    fifo_we  = 1'b0;
    ack      = '0;
    busy     = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_valid) begin
          data_d  = req_data[int'(pick_idx)*W +: W];
          win_d   = pick_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        // Reset suppresses the write so a discarded word is never half-delivered.
        if (!fifo_full && !reset) begin
          fifo_we    = 1'b1;
          ack[win_q] = 1'b1;
          rr_ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
          state_d    = ARB;
        end else if (fifo_full && stall_q != 8'hFF) begin
          stall_d = stall_q + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (reset) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      win_q    <= '0;
      data_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
    end
  end

  assign fifo_data = data_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level
// model: one pending word, a round-robin pointer and a saturating stall count.
module tb_fifo_wr_arbiter;
  localparam int W = 6;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_we;
  logic [W-1:0]   fifo_data;
  logic           busy;
  logic [7:0]     stall_cnt;

  logic [W-1:0]   slc [N];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = slc[i];
  end

  fifo_wr_arbiter #(.W(W), .N(N)) dut (
    .r_clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_data(fifo_data),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Model: a single pending word (or none), who owns it, where the next scan starts.
  bit         m_valid = 0;
  bit         m_pend;
  int         m_win;
  int         m_data;
  int         m_rr;
  int         m_stall;

  logic [7:0] wlog [$];
  logic [7:0] alog [$];
  logic [N-1:0] last_ack;
  int         wait_cnt [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_we;
    int exp_ack;
    if (!m_valid) return;
    exp_we  = m_pend && !fifo_full && !reset;
    exp_ack = exp_we ? (1 << m_win) : 0;
    chk("busy", 32'(busy), 32'(m_pend));
    chk("fifo_we", 32'(fifo_we), 32'(exp_we));
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("fifo_data", 32'(fifo_data), 32'(m_data));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic model_update();
    if (reset) begin
      m_valid = 1;
      m_pend  = 0;
      m_rr    = 0;
      m_data  = 0;
      m_win   = 0;
      m_stall = 0;
    end else if (!m_valid) begin
      return;
    end else if (m_pend) begin
      if (!fifo_full) begin
        m_pend = 0;
        m_rr   = (m_win + 1) % N;
      end else if (m_stall < 255) begin
        m_stall++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (req[c]) begin
          m_pend = 1;
          m_win  = c;
          m_data = int'(slc[c]);
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    last_ack = ack;
    if (fifo_we === 1'b1) begin
      wlog.push_back(8'(fifo_data));
      alog.push_back(8'(ack));
      $display("[TB] write data=%02h ack=%b stall_cnt=%0d", fifo_data, ack, stall_cnt);
    end
    if (ack != '0) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) wait_cnt[i] = 0;
        else if (req[i]) begin
          wait_cnt[i]++;
          tests++;
          if (wait_cnt[i] > N - 1) begin
            fails++;
            $display("FAIL fairness: req %0d waited %0d grants, limit %0d", i, wait_cnt[i], N - 1);
          end
        end
      end
    end
    @(posedge clk);
    model_update();
    if (reset) for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = N'($urandom);
    fifo_full = 1'($urandom);
    cycle();
    cycle();
    reset     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    wlog.delete();
    alog.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [7:0] d, input logic [7:0] a);
    if (idx >= wlog.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: write %0d missing, got %0d writes expected data %02h", name, idx, wlog.size(), d);
    end else begin
      chk({name, "_data"}, 32'(wlog[idx]), 32'(d));
      chk({name, "_ack"}, 32'(alog[idx]), 32'(a));
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin slc[i] = '0; wait_cnt[i] = 0; end

    // Reset state
    for (int i = 0; i < N; i++) slc[i] = W'($urandom);
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(fifo_we), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_data", 32'(fifo_data), 0);

    // Single request
    do_reset();
    req = 4'b0001; slc[0] = 6'h15;
    cycle();
    chk("single_we", 32'(fifo_we), 1);
    chk("single_dat", 32'(fifo_data), 32'h15);
    cycle();
    req = '0;
    cycle(); cycle();
    chk("single_cnt", 32'(wlog.size()), 1);
    chk_log("single", 0, 8'h15, 8'b0001);

    // All requesting: strict rotation
    do_reset();
    for (int i = 0; i < N; i++) slc[i] = W'(i + 1);
    req = 4'b1111;
    repeat (10) cycle();
    req = '0;
    cycle(); cycle();
    chk("rot_cnt", 32'(wlog.size()), 5);
    chk_log("rot0", 0, 8'd1, 8'b0001);
    chk_log("rot1", 1, 8'd2, 8'b0010);
    chk_log("rot2", 2, 8'd3, 8'b0100);
    chk_log("rot3", 3, 8'd4, 8'b1000);
    chk_log("rot4", 4, 8'd1, 8'b0001);

    // Full for 5 WRITE cycles
    do_reset();
    req = 4'b0100; slc[2] = 6'h2C; fifo_full = 1'b1;
    repeat (6) cycle();
    chk("full_stall", 32'(stall_cnt), 5);
    chk("full_nowr", 32'(wlog.size()), 0);
    fifo_full = 1'b0;
    cycle();
    req = '0;
    cycle();
    chk("full_cnt", 32'(wlog.size()), 1);
    chk_log("full", 0, 8'h2C, 8'b0100);
    chk("full_stall2", 32'(stall_cnt), 5);

    // Saturation
    do_reset();
    req = 4'b0001; fifo_full = 1'b1;
    repeat (301) cycle();
    chk("sat_stall", 32'(stall_cnt), 255);
    fifo_full = 1'b0;
    cycle();
    req = '0;
    cycle();
    chk("sat_stall2", 32'(stall_cnt), 255);

    // Reset during a stalled WRITE discards the word and restarts at pointer 0
    do_reset();
    req = 4'b0001; slc[0] = 6'h11;
    cycle(); cycle();
    req = 4'b0100; slc[2] = 6'h22; fifo_full = 1'b1;
    cycle(); cycle();
    reset = 1'b1; fifo_full = 1'b0;
    wlog.delete(); alog.delete();
    cycle();
    reset = 1'b0;
    chk("rstw_nowr", 32'(wlog.size()), 0);
    for (int i = 0; i < N; i++) slc[i] = W'(6'h30 + i);
    req = 4'b1111;
    cycle(); cycle();
    req = '0;
    cycle();
    chk_log("rstw", 0, 8'h30, 8'b0001);

    // Request dropped mid-WRITE still completes with the latched word
    do_reset();
    req = 4'b0100; slc[2] = 6'h2A; fifo_full = 1'b1;
    cycle();
    req = '0; slc[2] = 6'h05;
    cycle();
    fifo_full = 1'b0;
    cycle(); cycle();
    chk("drop_cnt", 32'(wlog.size()), 1);
    chk_log("drop", 0, 8'h2A, 8'b0100);

    // Random traffic: requesters hold req and data until acked
    do_reset();
    last_ack = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_ack[i]) begin
          req[i] = 1'($urandom);
          slc[i] = W'($urandom);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          slc[i] = W'($urandom);
        end
      end
      fifo_full = ($urandom_range(0, 9) < 3);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; req = '0; fifo_full = 1'b0;
    cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
